// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART tx/rx units and the tx arbiter.
//   BYTE_W      - UART payload width.
//   DIV_RATIO   - default baud divider shared with the tx/rx units
//                 (50 MHz / 115200 baud).
//   arb_state_t - tx arbiter FSM states.
package uart_pkg;
  localparam int BYTE_W    = 8;
  localparam int DIV_RATIO = 434;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_ACK,
    WAIT_DONE,
    GAP
  } arb_state_t;
endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// rr_picker: combinational first-set search over vld, beginning at ptr and
// wrapping modulo N_REQ.
//   vld   in  N_REQ  request vector
//   ptr   in  IDX_W  search start index (must be < N_REQ)
//   found out 1      some bit of vld is set
//   idx   out IDX_W  index of the first set bit at or after ptr
module rr_picker #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] vld,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);
  int j;

  // Scan offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= N_REQ) j = j - N_REQ;
      if (vld[IDX_W'(j)]) begin
        found = 1'b1;
        idx   = IDX_W'(j);
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between N_REQ byte sources.
// Accepts one byte per transaction (one-hot ready pulse), pulses act to the
// transmitter, owns it until busy_t falls, then enforces GAP_CYCLES idle
// cycles. A transmitter that never raises busy_t within ACK_TIMEOUT cycles
// sets the sticky err flag and the byte is dropped.
//   clk, rst        clock, asynchronous active-low reset
//   req_valid/data  per-requester byte offer (data stable while valid)
//   req_ready       one-hot one-cycle accept pulse
//   tx_data, act    registered byte and start pulse to the transmitter
//   busy_t          transmitter busy
//   grant_id        current/last owner
//   arb_busy        accept .. end of gap
//   err             sticky acknowledge timeout
// Build option: UART_ARB_FIXED_PRIO_EN selects fixed priority (lowest index
// wins, no pointer register) instead of round-robin.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int N_REQ       = 4,
  parameter  int ACK_TIMEOUT = 8,
  parameter  int GAP_CYCLES  = 2,
  localparam int GID_W       = $clog2(N_REQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [N_REQ-1:0][BYTE_W-1:0] req_data,
  output logic [N_REQ-1:0]             req_ready,
  output logic [BYTE_W-1:0]            tx_data,
  output logic                         act,
  input  logic                         busy_t,
  output logic [GID_W-1:0]             grant_id,
  output logic                         arb_busy,
  output logic                         err
);
  localparam int CNT_MAX = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  arb_state_t               state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d, cnt_inc;
  logic [N_REQ-1:0]         ready_q, ready_d;
  logic [BYTE_W-1:0]        tx_data_q, tx_data_d;
  logic                     act_q, act_d;
  logic [GID_W-1:0]         gid_q, gid_d;
  logic                     arb_busy_q, arb_busy_d;
  logic                     err_q, err_d;
  logic [GID_W-1:0]         pick_ptr;
  logic                     found;
  logic [GID_W-1:0]         win;

`ifdef UART_ARB_FIXED_PRIO_EN
  assign pick_ptr = '0;
`else
  logic [GID_W-1:0] ptr_q, ptr_d;
  assign pick_ptr = ptr_q;
`endif

  rr_picker #(.N_REQ(N_REQ), .IDX_W(GID_W)) u_pick (
    .vld   (req_valid),
    .ptr   (pick_ptr),
    .found (found),
    .idx   (win)
  );

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ready_d    = '0;
    tx_data_d  = tx_data_q;
    act_d      = 1'b0;
    gid_d      = gid_q;
    arb_busy_d = arb_busy_q;
    err_d      = err_q;
`ifndef UART_ARB_FIXED_PRIO_EN
    ptr_d      = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        // A busy transmitter we did not start is never handed a new byte.
        if (found && !busy_t) begin
          ready_d[win] = 1'b1;
          tx_data_d    = req_data[win];
          gid_d        = win;
          arb_busy_d   = 1'b1;
`ifndef UART_ARB_FIXED_PRIO_EN
          ptr_d        = (win == GID_W'(N_REQ - 1)) ? '0 : win + GID_W'(1);
`endif
          state_d      = START;
        end
      end
      START: begin
        act_d   = 1'b1;
        cnt_d   = '0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (busy_t) begin
          state_d = WAIT_DONE;
        end else if (cnt_inc == CNT_W'(ACK_TIMEOUT)) begin
          err_d = 1'b1;
          cnt_d = '0;
          if (GAP_CYCLES == 0) begin
            state_d    = IDLE;
            arb_busy_d = 1'b0;
          end else begin
            state_d = GAP;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      WAIT_DONE: begin
        if (!busy_t) begin
          cnt_d = '0;
          if (GAP_CYCLES == 0) begin
            state_d    = IDLE;
            arb_busy_d = 1'b0;
          end else begin
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (cnt_inc == CNT_W'(GAP_CYCLES)) begin
          state_d    = IDLE;
          arb_busy_d = 1'b0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ready_q    <= '0;
      tx_data_q  <= '0;
      act_q      <= 1'b0;
      gid_q      <= '0;
      arb_busy_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ready_q    <= ready_d;
      tx_data_q  <= tx_data_d;
      act_q      <= act_d;
      gid_q      <= gid_d;
      arb_busy_q <= arb_busy_d;
      err_q      <= err_d;
    end
  end

`ifndef UART_ARB_FIXED_PRIO_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr_q <= '0;
    else      ptr_q <= ptr_d;
  end
`endif

  assign req_ready = ready_q;
  assign tx_data   = tx_data_q;
  assign act       = act_q;
  assign grant_id  = gid_q;
  assign arb_busy  = arb_busy_q;
  assign err       = err_q;
endmodule
